univ_shift_reg: RTL

//   Parametrised universal shift register: hold, shift right, shift left and parallel load.

---
 rtl/univ_shift_reg_if.sv | 34 +++
 rtl/univ_shift_reg.sv | 113 +++++++++++
 2 files changed

// File: rtl/univ_shift_reg_if.sv
// Control, data and status bundle for univ_shift_reg.
// The rot signal and its modport entries exist only when ROTATE_EN is defined.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             en;
   logic [1:0]       mode;
   logic             si_msb;
   logic             si_lsb;
   logic [WIDTH-1:0] pdata;
   logic             start;
   logic [CNT_W-1:0] cnt;
   logic             dir;
`ifdef ROTATE_EN
   logic             rot;
`endif
   logic [WIDTH-1:0] q;
   logic             so;
   logic             busy;
   logic             done;

`ifdef ROTATE_EN
   modport master (output en, mode, si_msb, si_lsb, pdata, start, cnt, dir, rot,
                   input  q, so, busy, done);
   modport slave  (input  en, mode, si_msb, si_lsb, pdata, start, cnt, dir, rot,
                   output q, so, busy, done);
`else
   modport master (output en, mode, si_msb, si_lsb, pdata, start, cnt, dir,
                   input  q, so, busy, done);
   modport slave  (input  en, mode, si_msb, si_lsb, pdata, start, cnt, dir,
                   output q, so, busy, done);
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with an autonomous burst shifter.
// Define ROTATE_EN to add the rot input, which turns every shift into a rotate.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   univ_shift_reg_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] q_r;
   logic             so_r;
   logic             busy_r;
   logic             done_r;
   logic [CNT_W-1:0] count;
   logic             dir_r;

   logic             fill_msb;
   logic             fill_lsb;
   logic [WIDTH-1:0] right_q;
   logic [WIDTH-1:0] left_q;

   // Bit entering the vacated end: serial input normally, the bit leaving the other end when rotating.
   always_comb begin
`ifdef ROTATE_EN
      fill_msb = bus.rot ? q_r[0]       : bus.si_msb;
      fill_lsb = bus.rot ? q_r[WIDTH-1] : bus.si_lsb;
`else
      fill_msb = bus.si_msb;
      fill_lsb = bus.si_lsb;
`endif
      right_q  = {fill_msb, q_r[WIDTH-1:1]};
      left_q   = {q_r[WIDTH-2:0], fill_lsb};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         q_r    <= '0;
         so_r   <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         count  <= '0;
         dir_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en) begin
                  if (bus.start) begin
                     if (bus.cnt != '0) begin
                        count  <= bus.cnt;
                        dir_r  <= bus.dir;
                        busy_r <= 1'b1;
                        state  <= BURST;
                     end else begin
                        done_r <= 1'b1;
                        state  <= FIN;
                     end
                  end else begin
                     case (bus.mode)
                        2'b01: begin
                           q_r  <= right_q;
                           so_r <= q_r[0];
                        end
                        2'b10: begin
                           q_r  <= left_q;
                           so_r <= q_r[WIDTH-1];
                        end
                        2'b11: q_r <= bus.pdata;
                        default: ;
                     endcase
                  end
               end
            end
            BURST: begin
               if (bus.en) begin
                  if (dir_r) begin
                     q_r  <= left_q;
                     so_r <= q_r[WIDTH-1];
                  end else begin
                     q_r  <= right_q;
                     so_r <= q_r[0];
                  end
                  count <= count - CNT_W'(1);
                  // The shift that empties the count is the final one.
                  if (count == CNT_W'(1)) begin
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     state  <= FIN;
                  end
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.q    = q_r;
   assign bus.so   = so_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule
